// File: rtl/vram_arb.sv
// rtl/vram_arb.sv - banked video RAM shared by a fixed-latency video port and a host port
// Video wins each cycle until the host has been blocked MAX_WAIT times; then the host is forced through.
module vram_arb #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int BANK_ADDR_W = 14,
  parameter int READ_LAT    = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_sel,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic [DATA_W-1:0]     vid_data_out,
  output logic                  vid_valid,
  output logic                  vid_miss,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [DATA_W/8-1:0]   host_mask,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_data_in,
  output logic                  host_ack,
  output logic [DATA_W-1:0]     host_data_out
);
  localparam int BANK_W    = ADDR_W - BANK_ADDR_W;
  localparam int NUM_BANKS = 2 ** BANK_W;
  localparam int LANES     = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic       busy_cnt;

  logic host_elig, host_force, issue_host, issue_vid, drop_vid;
  logic acc_en, acc_we;
  logic [ADDR_W-1:0]      acc_addr;
  logic [BANK_W-1:0]      acc_bank;
  logic [BANK_ADDR_W-1:0] acc_off;

  // No access is issued while reset is high, so a pending write is never committed by it.
  always_comb begin
    host_elig  = host_req && (state == ST_IDLE || state == ST_WAIT);
    host_force = host_elig && (state == ST_WAIT) && (wait_cnt == 4'(MAX_WAIT));
    issue_host = !reset && host_elig && (!vid_sel || host_force);
    issue_vid  = !reset && vid_sel && !host_force;
    drop_vid   = !reset && vid_sel && host_force;
  end

  assign acc_en   = issue_host || issue_vid;
  assign acc_we   = issue_host && host_wr;
  assign acc_addr = issue_host ? host_addr : vid_addr;
  assign acc_bank = acc_addr[ADDR_W-1:BANK_ADDR_W];
  assign acc_off  = acc_addr[BANK_ADDR_W-1:0];

  logic [DATA_W-1:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [2**BANK_ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (acc_en && acc_bank == BANK_W'(b)) begin
        if (acc_we) begin
          for (int i = 0; i < LANES; i++) begin
            if (host_mask[i]) mem[acc_off][i*8 +: 8] <= host_data_in[i*8 +: 8];
          end
        end else begin
          rd_q <= mem[acc_off];
        end
      end
    end

    assign bank_rd[b] = rd_q;
  end

  logic              s1_vid, s1_miss, s1_ack, s1_hrd;
  logic [BANK_W-1:0] sel_q;
  logic [DATA_W-1:0] mux_data, vid_hold, host_hold;

  assign mux_data = bank_rd[sel_q];

  // sel_q follows the issued access so each result is steered from its own bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vid    <= 1'b0;
      s1_miss   <= 1'b0;
      s1_ack    <= 1'b0;
      s1_hrd    <= 1'b0;
      sel_q     <= '0;
      vid_hold  <= '0;
      host_hold <= '0;
    end else begin
      s1_vid  <= issue_vid;
      s1_miss <= drop_vid;
      s1_ack  <= issue_host;
      s1_hrd  <= issue_host && !host_wr;
      if (acc_en) sel_q <= acc_bank;
      if (s1_vid) vid_hold <= mux_data;
      if (s1_hrd) host_hold <= mux_data;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic s2_vid, s2_miss, s2_ack;

    always_ff @(posedge clk) begin
      if (reset) begin
        s2_vid  <= 1'b0;
        s2_miss <= 1'b0;
        s2_ack  <= 1'b0;
      end else begin
        s2_vid  <= s1_vid;
        s2_miss <= s1_miss;
        s2_ack  <= s1_ack;
      end
    end

    assign vid_valid     = s2_vid;
    assign vid_miss      = s2_miss;
    assign host_ack      = s2_ack;
    assign vid_data_out  = vid_hold;
    assign host_data_out = host_hold;
  end else begin : g_lat1
    assign vid_valid     = s1_vid;
    assign vid_miss      = s1_miss;
    assign host_ack      = s1_ack;
    assign vid_data_out  = s1_vid ? mux_data : vid_hold;
    assign host_data_out = s1_hrd ? mux_data : host_hold;
  end

  // A blocked cycle in IDLE already counts toward the force threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      busy_cnt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (issue_host) begin
            state    <= ST_BUSY;
            wait_cnt <= 4'd0;
            busy_cnt <= 1'b0;
          end else if (host_req) begin
            state    <= ST_WAIT;
            wait_cnt <= wait_cnt + 4'd1;
          end else begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
          end
        end
        ST_BUSY: begin
          if (busy_cnt == 1'(READ_LAT - 1)) state <= ST_IDLE;
          else busy_cnt <= busy_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arb.sv
// tb/tb_vram_arb.sv - directed and randomized checks of vram_arb (READ_LAT 1 and 2) against a behavioural model
module tb_vram_arb;
  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset         [2];
  logic          vid_sel       [2];
  logic [AW-1:0] vid_addr      [2];
  logic [DW-1:0] vid_data_out  [2];
  logic          vid_valid     [2];
  logic          vid_miss      [2];
  logic          host_req      [2];
  logic          host_wr       [2];
  logic [1:0]    host_mask     [2];
  logic [AW-1:0] host_addr     [2];
  logic [DW-1:0] host_data_in  [2];
  logic          host_ack      [2];
  logic [DW-1:0] host_data_out [2];

  vram_arb #(.READ_LAT(1), .MAX_WAIT(MAXW)) u_lat1 (
    .clk(clk), .reset(reset[0]),
    .vid_sel(vid_sel[0]), .vid_addr(vid_addr[0]), .vid_data_out(vid_data_out[0]),
    .vid_valid(vid_valid[0]), .vid_miss(vid_miss[0]),
    .host_req(host_req[0]), .host_wr(host_wr[0]), .host_mask(host_mask[0]),
    .host_addr(host_addr[0]), .host_data_in(host_data_in[0]),
    .host_ack(host_ack[0]), .host_data_out(host_data_out[0])
  );

  vram_arb #(.READ_LAT(2), .MAX_WAIT(MAXW)) u_lat2 (
    .clk(clk), .reset(reset[1]),
    .vid_sel(vid_sel[1]), .vid_addr(vid_addr[1]), .vid_data_out(vid_data_out[1]),
    .vid_valid(vid_valid[1]), .vid_miss(vid_miss[1]),
    .host_req(host_req[1]), .host_wr(host_wr[1]), .host_mask(host_mask[1]),
    .host_addr(host_addr[1]), .host_data_in(host_data_in[1]),
    .host_ack(host_ack[1]), .host_data_out(host_data_out[1])
  );

  int cyc;
  int n_checks;
  int n_pass;

  logic [DW-1:0] mem_m [int];
  bit            armed [2];
  bit            e_vid [2][4];
  bit            e_miss[2][4];
  bit            e_ack [2][4];
  bit            e_hrd [2][4];
  logic [DW-1:0] e_dat [2][4];
  logic [DW-1:0] exp_vd[2];
  logic [DW-1:0] exp_hd[2];
  int            busy_until[2];
  int            blocked[2];

  logic          obs_vv [2];
  logic          obs_vm [2];
  logic          obs_ack[2];
  logic [DW-1:0] obs_vd [2];
  logic [DW-1:0] obs_hd [2];

  logic [15:0] pool [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
  endtask

  function automatic int mkey(input int d, input logic [15:0] a);
    return (d << 16) | int'(a);
  endfunction

  // Per-cycle reference: outputs due this cycle are compared, then this cycle's inputs are arbitrated.
  task automatic model_cycle(input int d);
    int s, t, lat, k;
    logic [DW-1:0] w;
    bit elig, frc, hiss, viss;
    lat = d + 1;
    s = cyc % 4;
    obs_vv[d]  = vid_valid[d];
    obs_vm[d]  = vid_miss[d];
    obs_ack[d] = host_ack[d];
    obs_vd[d]  = vid_data_out[d];
    obs_hd[d]  = host_data_out[d];
    if (armed[d]) begin
      if (e_vid[d][s]) exp_vd[d] = e_dat[d][s];
      if (e_hrd[d][s]) exp_hd[d] = e_dat[d][s];
      check($sformatf("L%0d vid_valid", lat), 32'(obs_vv[d]), 32'(e_vid[d][s]));
      check($sformatf("L%0d vid_miss", lat), 32'(obs_vm[d]), 32'(e_miss[d][s]));
      check($sformatf("L%0d host_ack", lat), 32'(obs_ack[d]), 32'(e_ack[d][s]));
      check($sformatf("L%0d vid_data_out", lat), 32'(obs_vd[d]), 32'(exp_vd[d]));
      check($sformatf("L%0d host_data_out", lat), 32'(obs_hd[d]), 32'(exp_hd[d]));
    end
    e_vid[d][s] = 0; e_miss[d][s] = 0; e_ack[d][s] = 0; e_hrd[d][s] = 0;
    if (reset[d]) begin
      for (k = 0; k < 4; k++) begin
        e_vid[d][k] = 0; e_miss[d][k] = 0; e_ack[d][k] = 0; e_hrd[d][k] = 0;
      end
      exp_vd[d] = '0;
      exp_hd[d] = '0;
      busy_until[d] = cyc;
      blocked[d] = 0;
      armed[d] = 1;
    end else if (armed[d]) begin
      elig = host_req[d] && (cyc > busy_until[d]);
      frc  = elig && (blocked[d] == MAXW);
      hiss = elig && (!vid_sel[d] || frc);
      viss = vid_sel[d] && !frc;
      t = (cyc + lat) % 4;
      if (viss) begin
        e_vid[d][t] = 1;
        e_dat[d][t] = mem_m[mkey(d, vid_addr[d])];
      end
      if (vid_sel[d] && frc) e_miss[d][t] = 1;
      if (hiss) begin
        e_ack[d][t] = 1;
        busy_until[d] = cyc + lat;
        blocked[d] = 0;
        if (host_wr[d]) begin
          w = mem_m.exists(mkey(d, host_addr[d])) ? mem_m[mkey(d, host_addr[d])] : '0;
          for (k = 0; k < 2; k++)
            if (host_mask[d][k]) w[k*8 +: 8] = host_data_in[d][k*8 +: 8];
          mem_m[mkey(d, host_addr[d])] = w;
        end else begin
          e_hrd[d][t] = 1;
          e_dat[d][t] = mem_m[mkey(d, host_addr[d])];
        end
      end else if (elig) begin
        blocked[d]++;
      end else begin
        blocked[d] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic host_op(input int d, input bit wr, input logic [1:0] mask, input logic [15:0] addr,
                         input logic [15:0] data, input bit keep, output int ack_cyc, output logic [15:0] rdata);
    int n;
    host_req[d] = 1'b1;
    host_wr[d] = wr;
    host_mask[d] = mask;
    host_addr[d] = addr;
    host_data_in[d] = data;
    ack_cyc = -1;
    rdata = 'x;
    n = 0;
    while (ack_cyc < 0 && n < 40) begin
      cycle();
      n++;
      if (obs_ack[d]) begin
        ack_cyc = cyc - 1;
        rdata = obs_hd[d];
      end
    end
    if (ack_cyc < 0) check("host_op_timeout", 32'(n), 32'd0);
    if (!keep) host_req[d] = 1'b0;
  endtask

  task automatic new_fields(input int d);
    host_req[d] = 1'b1;
    host_wr[d] = 1'($urandom);
    host_mask[d] = 2'($urandom);
    host_addr[d] = pool[$urandom_range(0, 15)];
    host_data_in[d] = 16'($urandom);
  endtask

  initial begin
    int ac, t0, prev, ack_rel, miss_rel, nvalid, nack, first_v;
    int age[2];
    logic [15:0] rd;

    pool = '{16'h0010, 16'h0020, 16'h3FFF, 16'h0100,
             16'h4000, 16'h4001, 16'h7FFF, 16'h5555,
             16'h8000, 16'h8123, 16'hBFFF, 16'hA0A0,
             16'hC000, 16'hC001, 16'hFFFF, 16'hE0E0};
    cyc = 0; n_checks = 0; n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; vid_sel[d] = 1'b0; vid_addr[d] = '0;
      host_req[d] = 1'b0; host_wr[d] = 1'b0; host_mask[d] = '0;
      host_addr[d] = '0; host_data_in[d] = '0;
      armed[d] = 0; busy_until[d] = -1; blocked[d] = 0; age[d] = 0;
      exp_vd[d] = '0; exp_hd[d] = '0;
      for (int k = 0; k < 4; k++) begin
        e_vid[d][k] = 0; e_miss[d][k] = 0; e_ack[d][k] = 0; e_hrd[d][k] = 0; e_dat[d][k] = '0;
      end
    end

    repeat (3) cycle();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      check("reset vid_valid", 32'(obs_vv[d]), 32'd0);
      check("reset vid_miss", 32'(obs_vm[d]), 32'd0);
      check("reset host_ack", 32'(obs_ack[d]), 32'd0);
      check("reset vid_data_out", 32'(obs_vd[d]), 32'd0);
      check("reset host_data_out", 32'(obs_hd[d]), 32'd0);
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        host_op(d, 1'b1, 2'b11, pool[i], (pool[i] == 16'h0020) ? 16'h0000 : 16'($urandom), 1'b0, ac, rd);

    // bank boundary
    host_op(0, 1'b1, 2'b11, 16'h3FFF, 16'hA5A5, 1'b0, ac, rd);
    host_op(0, 1'b1, 2'b11, 16'h4000, 16'h5A5A, 1'b0, ac, rd);
    vid_sel[0] = 1'b1; vid_addr[0] = 16'h3FFF;
    cycle();
    vid_addr[0] = 16'h4000;
    cycle();
    check("bank_lo_valid", 32'(obs_vv[0]), 32'd1);
    check("bank_lo_data", 32'(obs_vd[0]), 32'h0000A5A5);
    vid_sel[0] = 1'b0;
    cycle();
    check("bank_hi_valid", 32'(obs_vv[0]), 32'd1);
    check("bank_hi_data", 32'(obs_vd[0]), 32'h00005A5A);

    // masked write, both latencies
    for (int d = 0; d < 2; d++) begin
      host_op(d, 1'b1, 2'b11, 16'h0010, 16'h1234, 1'b0, ac, rd);
      host_op(d, 1'b1, 2'b10, 16'h0010, 16'hFFFF, 1'b0, ac, rd);
      t0 = cyc;
      host_op(d, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, ac, rd);
      check("mask_rdata", 32'(rd), 32'h0000FF34);
      check("mask_ack_lat", 32'(ac - t0), 32'(d + 1));
    end

    // starvation under continuous video
    vid_sel[0] = 1'b1;
    host_req[0] = 1'b1; host_wr[0] = 1'b0; host_addr[0] = 16'h4001;
    ack_rel = -1; miss_rel = -1; nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      vid_addr[0] = pool[$urandom_range(0, 15)];
      cycle();
      if (obs_ack[0] && ack_rel < 0) begin
        ack_rel = k;
        host_req[0] = 1'b0;
      end
      if (obs_vm[0]) miss_rel = k;
      if (obs_vv[0]) nvalid++;
    end
    vid_sel[0] = 1'b0;
    cycle();
    check("starve_ack_cycle", 32'(ack_rel), 32'd5);
    check("starve_miss_cycle", 32'(miss_rel), 32'd5);
    check("starve_valid_count", 32'(nvalid), 32'd6);

    // READ_LAT=2, alternating video/host reads over all banks
    host_req[1] = 1'b1; host_wr[1] = 1'b0; host_addr[1] = pool[4 + $urandom_range(0, 3)];
    first_v = -1;
    for (int k = 0; k < 24; k++) begin
      vid_sel[1] = (k % 2 == 0);
      vid_addr[1] = pool[(k % 4) * 4 + $urandom_range(0, 3)];
      cycle();
      if (obs_vv[1] && first_v < 0) first_v = k;
      if (obs_ack[1]) host_addr[1] = pool[((k + 1) % 4) * 4 + $urandom_range(0, 3)];
    end
    host_req[1] = 1'b0; vid_sel[1] = 1'b0;
    cycle();
    cycle();
    check("lat2_first_valid", 32'(first_v), 32'd2);

    // reset during a WAIT-state write
    vid_sel[0] = 1'b1; vid_addr[0] = 16'h3FFF;
    host_req[0] = 1'b1; host_wr[0] = 1'b1; host_mask[0] = 2'b11;
    host_addr[0] = 16'h0020; host_data_in[0] = 16'hBEEF;
    nack = 0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      if (obs_ack[0]) nack++;
    end
    reset[0] = 1'b1; host_req[0] = 1'b0; vid_sel[0] = 1'b0;
    cycle();
    if (obs_ack[0]) nack++;
    reset[0] = 1'b0;
    cycle();
    check("rst_vid_valid", 32'(obs_vv[0]), 32'd0);
    check("rst_vid_miss", 32'(obs_vm[0]), 32'd0);
    check("rst_host_ack", 32'(obs_ack[0]), 32'd0);
    check("rst_vid_data", 32'(obs_vd[0]), 32'd0);
    check("rst_host_data", 32'(obs_hd[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (obs_ack[0]) nack++;
    end
    check("rst_no_ack", 32'(nack), 32'd0);
    host_op(0, 1'b0, 2'b00, 16'h0020, 16'h0000, 1'b0, ac, rd);
    check("rst_write_discarded", 32'(rd), 32'h00000000);

    // back-to-back host operations
    for (int d = 0; d < 2; d++) begin
      prev = -1;
      for (int j = 0; j < 5; j++) begin
        host_op(d, 1'($urandom), 2'($urandom), pool[$urandom_range(0, 15)], 16'($urandom), j < 4, ac, rd);
        if (j > 0) check("b2b_rate", 32'(ac - prev), 32'(d + 2));
        prev = ac;
      end
    end

    // randomized traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      for (int d = 0; d < 2; d++) begin
        reset[d] = ($urandom_range(0, 299) == 0);
        vid_sel[d] = ($urandom_range(0, 9) < 6);
        vid_addr[d] = pool[$urandom_range(0, 15)];
        if (reset[d]) begin
          host_req[d] = 1'b0;
          age[d] = 0;
        end else if (host_req[d]) begin
          if (obs_ack[d]) begin
            age[d] = 0;
            if ($urandom_range(0, 1) == 0) new_fields(d);
            else host_req[d] = 1'b0;
          end else begin
            age[d]++;
            if (age[d] > 40) begin
              check("host_ack_timeout", 32'(age[d]), 32'd40);
              host_req[d] = 1'b0;
              age[d] = 0;
            end
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_fields(d);
          age[d] = 0;
        end
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b0; vid_sel[d] = 1'b0; host_req[d] = 1'b0;
    end
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
